// File: rtl/riscv_defines.sv
// Shared core definitions.
// Instruction memory response owner encoding.
package riscv_defines;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DBG  = 2'd2
   } imem_owner_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, debug and SRAM bus bundle around imem_arbiter.
// master = requester/SRAM side, slave = arbiter side.
interface imem_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        dbg_req;
   logic        dbg_we;
   logic [3:0]  dbg_be;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;

   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        starve;

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata,
      input  starve
   );

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata,
      output starve
   );

endinterface

// File: rtl/imem_arbiter.sv
// Instruction SRAM arbiter: fetch has priority, debug port
// is force-granted after MAX_WAIT consecutive refusals.
module imem_arbiter
   import riscv_defines::*;
#(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,

   input  logic        dbg_req_i,
   input  logic        dbg_we_i,
   input  logic [3:0]  dbg_be_i,
   input  logic [31:0] dbg_addr_i,
   input  logic [31:0] dbg_wdata_i,
   output logic        dbg_gnt_o,
   output logic        dbg_rvalid_o,
   output logic [31:0] dbg_rdata_o,

   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,

   output logic        starve_o
);

   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   logic [WW-1:0] wait_q, wait_d;
   imem_owner_t   owner_q, owner_d;
   logic          we_q, we_d;
   logic          ready_q;
   logic          if_gnt, dbg_gnt;

   // Grants stay blocked until the first edge after reset.
   always_comb begin
      dbg_gnt = ready_q & dbg_req_i &
                (~if_req_i | (wait_q == WAIT_MAX));
      if_gnt  = ready_q & if_req_i & ~dbg_gnt;
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      unique case (1'b1)
         dbg_gnt: begin
            mem_req_o   = 1'b1;
            mem_we_o    = dbg_we_i;
            mem_be_o    = dbg_be_i;
            mem_addr_o  = dbg_addr_i & WORD_MASK;
            mem_wdata_o = dbg_wdata_i;
         end
         if_gnt: begin
            mem_req_o   = 1'b1;
            mem_be_o    = 4'hF;
            mem_addr_o  = if_addr_i & WORD_MASK;
         end
         default: ;
      endcase
   end

   always_comb begin
      wait_d = '0;
      if (dbg_req_i && !dbg_gnt) begin
         wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      we_d    = 1'b0;
      unique case (1'b1)
         dbg_gnt: begin
            owner_d = OWN_DBG;
            we_d    = dbg_we_i;
         end
         if_gnt: owner_d = OWN_IF;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q  <= '0;
         owner_q <= OWN_NONE;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         ready_q <= 1'b1;
      end
   end

   always_comb begin
      if_gnt_o     = if_gnt;
      dbg_gnt_o    = dbg_gnt;
      starve_o     = dbg_gnt & if_req_i;
      if_rvalid_o  = (owner_q == OWN_IF);
      dbg_rvalid_o = (owner_q == OWN_DBG);
      if_rdata_o   = if_rvalid_o ? mem_rdata_i : 32'h0;
      // Write acks carry no data.
      dbg_rdata_o  = (dbg_rvalid_o && !we_q) ? mem_rdata_i : 32'h0;
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter with an SRAM stub
// and a per-cycle reference model of grants and responses.
module tb_imem_arbiter;

   localparam int MW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   imem_arbiter_if bus ();

   imem_arbiter #(.MAX_WAIT(MW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_i     (bus.if_req),
      .if_addr_i    (bus.if_addr),
      .if_gnt_o     (bus.if_gnt),
      .if_rvalid_o  (bus.if_rvalid),
      .if_rdata_o   (bus.if_rdata),
      .dbg_req_i    (bus.dbg_req),
      .dbg_we_i     (bus.dbg_we),
      .dbg_be_i     (bus.dbg_be),
      .dbg_addr_i   (bus.dbg_addr),
      .dbg_wdata_i  (bus.dbg_wdata),
      .dbg_gnt_o    (bus.dbg_gnt),
      .dbg_rvalid_o (bus.dbg_rvalid),
      .dbg_rdata_o  (bus.dbg_rdata),
      .mem_req_o    (bus.mem_req),
      .mem_we_o     (bus.mem_we),
      .mem_be_o     (bus.mem_be),
      .mem_addr_o   (bus.mem_addr),
      .mem_wdata_o  (bus.mem_wdata),
      .mem_rdata_i  (bus.mem_rdata),
      .starve_o     (bus.starve)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // SRAM stub: reads return data next cycle, idle/write cycles return junk.
   logic [31:0] sram [0:255];
   logic [31:0] rd_word;
   assign bus.mem_rdata = rd_word;

   function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_req && bus.mem_we) begin
         sram[bus.mem_addr[9:2]] <= merge(sram[bus.mem_addr[9:2]],
                                          bus.mem_wdata, bus.mem_be);
         rd_word <= 32'hBAD0_BAD0;
      end else if (bus.mem_req) begin
         rd_word <= sram[bus.mem_addr[9:2]];
      end else begin
         rd_word <= 32'h5A5A_5A5A;
      end
   end

   // Reference model: refusal count, readiness, last granted access.
   int          m_wait;
   bit          m_ready;
   bit          p_vld, p_dbg, p_we;
   logic [31:0] p_data;

   function automatic bit exp_dbg_gnt();
      return m_ready && bus.dbg_req && (!bus.if_req || m_wait >= MW);
   endfunction

   function automatic bit exp_if_gnt();
      return m_ready && bus.if_req && !exp_dbg_gnt();
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wait  <= 0;
         m_ready <= 1'b0;
         p_vld   <= 1'b0;
         p_dbg   <= 1'b0;
         p_we    <= 1'b0;
         p_data  <= 32'h0;
      end else begin
         m_ready <= 1'b1;
         p_vld   <= exp_dbg_gnt() || exp_if_gnt();
         p_dbg   <= exp_dbg_gnt();
         p_we    <= exp_dbg_gnt() && bus.dbg_we;
         if (exp_dbg_gnt())
            p_data <= sram[bus.dbg_addr[9:2]];
         else
            p_data <= sram[bus.if_addr[9:2]];
         if (bus.dbg_req && !exp_dbg_gnt())
            m_wait <= (m_wait >= MW) ? MW : m_wait + 1;
         else
            m_wait <= 0;
      end
   end

   always @(negedge clk) begin
      bit dg, ig;
      logic [31:0] ea;
      dg = exp_dbg_gnt();
      ig = exp_if_gnt();
      ea = dg ? (bus.dbg_addr & 32'hFFFF_FFFC) :
           ig ? (bus.if_addr & 32'hFFFF_FFFC) : 32'h0;
      chk("if_gnt", {31'b0, bus.if_gnt}, {31'b0, ig});
      chk("dbg_gnt", {31'b0, bus.dbg_gnt}, {31'b0, dg});
      chk("starve", {31'b0, bus.starve}, {31'b0, dg && bus.if_req});
      chk("mem_req", {31'b0, bus.mem_req}, {31'b0, dg || ig});
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, dg && bus.dbg_we});
      chk("mem_be", {28'b0, bus.mem_be},
          {28'b0, dg ? bus.dbg_be : ig ? 4'hF : 4'h0});
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_wdata", bus.mem_wdata, dg ? bus.dbg_wdata : 32'h0);
      chk("if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, p_vld && !p_dbg});
      chk("if_rdata", bus.if_rdata, (p_vld && !p_dbg) ? p_data : 32'h0);
      chk("dbg_rvalid", {31'b0, bus.dbg_rvalid}, {31'b0, p_vld && p_dbg});
      chk("dbg_rdata", bus.dbg_rdata,
          (p_vld && p_dbg && !p_we) ? p_data : 32'h0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input bit ir, input logic [31:0] ia,
      input bit dr, input bit dw, input logic [3:0] be,
      input logic [31:0] da, input logic [31:0] wd);
      bus.if_req    = ir;
      bus.if_addr   = ia;
      bus.dbg_req   = dr;
      bus.dbg_we    = dw;
      bus.dbg_be    = be;
      bus.dbg_addr  = da;
      bus.dbg_wdata = wd;
   endtask

   // Holds fetch plus a debug read until debug wins; returns fetch grants seen.
   task automatic contend(input logic [31:0] da, output int fg,
                          output int gcyc);
      fg = 0;
      gcyc = -1;
      drv(1, 32'h200, 1, 0, 4'h0, da, 32'h0);
      for (int c = 0; c < 20 && gcyc < 0; c++) begin
         @(negedge clk);
         if (bus.dbg_gnt) begin
            gcyc = c;
            chk("starve_at_force", {31'b0, bus.starve}, 32'h1);
         end
         if (bus.if_gnt) fg++;
         step();
         bus.if_addr = bus.if_addr + 32'h4;
      end
      bus.dbg_req = 1'b0;
      if (gcyc < 0) chk("contend_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      int fg, gc;
      for (int i = 0; i < 256; i++) sram[i] = 32'h1000_0000 + i;
      drv(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Fetch stream.
      drv(1, 32'h80, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t1_gnt0", {31'b0, bus.if_gnt}, 32'h1);
      step();
      bus.if_addr = 32'h84;
      @(negedge clk);
      chk("t1_rd0", bus.if_rdata, 32'h1000_0020);
      step();
      bus.if_addr = 32'h88;
      @(negedge clk);
      chk("t1_rd1", bus.if_rdata, 32'h1000_0021);
      step();
      bus.if_req = 1'b0;
      @(negedge clk);
      chk("t1_rd2", bus.if_rdata, 32'h1000_0022);
      chk("t1_dbgrv", {31'b0, bus.dbg_rvalid}, 32'h0);
      step();

      // Debug write then read.
      drv(0, 0, 1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("t2_wgnt", {31'b0, bus.dbg_gnt}, 32'h1);
      step();
      drv(0, 0, 1, 0, 4'h0, 32'h100, 32'h0);
      @(negedge clk);
      chk("t2_wack", {31'b0, bus.dbg_rvalid}, 32'h1);
      chk("t2_wack_data", bus.dbg_rdata, 32'h0);
      step();
      bus.dbg_req = 1'b0;
      @(negedge clk);
      chk("t2_rd", bus.dbg_rdata, 32'hDEAD_BEEF);
      step();

      // Starvation guard.
      contend(32'h104, fg, gc);
      chk("t3_fetches", fg, MW);
      chk("t3_gnt_cycle", gc, MW);
      @(negedge clk);
      chk("t3_fetch_resume", {31'b0, bus.if_gnt}, 32'h1);
      step();

      // Byte write with misaligned address.
      drv(0, 0, 1, 1, 4'hF, 32'h40, 32'h1122_3344);
      step();
      drv(0, 0, 1, 1, 4'b0010, 32'h41, 32'h0000_AB00);
      @(negedge clk);
      chk("t4_addr_mask", bus.mem_addr, 32'h40);
      step();
      drv(0, 0, 1, 0, 4'h0, 32'h40, 32'h0);
      step();
      bus.dbg_req = 1'b0;
      @(negedge clk);
      chk("t4_merge", bus.dbg_rdata, 32'h1122_AB44);
      step();

      // Abandoned debug request.
      drv(1, 32'h300, 1, 0, 4'h0, 32'h8, 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("t6_no_dbg", {31'b0, bus.dbg_gnt}, 32'h0);
         step();
      end
      bus.dbg_req = 1'b0;
      repeat (2) step();
      contend(32'h8, fg, gc);
      chk("t6_restart", fg, MW);
      bus.if_req = 1'b0;
      step();

      // Reset with a fetch in flight.
      drv(1, 32'h380, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t5_gnt", {31'b0, bus.if_gnt}, 32'h1);
      #1 rst_n = 1'b0;
      #1 chk("t5_rst_gnt", {31'b0, bus.if_gnt}, 32'h0);
      @(negedge clk);
      chk("t5_dropped", {31'b0, bus.if_rvalid}, 32'h0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_first_gnt", {31'b0, bus.if_gnt}, 32'h0);
      chk("t5_first_req", {31'b0, bus.mem_req}, 32'h0);
      chk("t5_first_rv", {31'b0, bus.if_rvalid}, 32'h0);
      step();
      @(negedge clk);
      chk("t5_regrant", {31'b0, bus.if_gnt}, 32'h1);
      step();
      bus.if_req = 1'b0;
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
